// File: rtl/param_bit_pkg.sv
// Shared types and helpers for the parameter bit serializer.
//   state_t   : serializer FSM states
//   idx_width : index width for a vector of w bits (never below 1)
package param_bit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A 1-bit vector still needs a 1-bit index so that VAL[0] can be formed.
    function automatic int unsigned idx_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/param_bit_idx_ctr.sv
// Index/pass counter that walks the bit positions of a W-bit constant,
// REPEAT times, in ascending or descending order.
//   clk, rst  : clock, synchronous active-high reset
//   restart   : load the start index and clear the pass count
//   advance   : step to the next beat (index step, or wrap into next pass)
//   idx       : current index
//   last_idx  : current index is the end index of a pass
//   last_pass : current pass is the final one
//   idx_nxt   : index value that will be registered on this edge
//   last_nxt  : the beat registered on this edge is the final beat of the run
module param_bit_idx_ctr
    import param_bit_pkg::*;
#(
    parameter int unsigned W         = 1,
    parameter int unsigned REPEAT    = 1,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      restart,
    input  logic                      advance,
    output logic [idx_width(W)-1:0]   idx,
    output logic                      last_idx,
    output logic                      last_pass,
    output logic [idx_width(W)-1:0]   idx_nxt,
    output logic                      last_nxt
);

    localparam int unsigned IW = idx_width(W);
    localparam int unsigned PW = idx_width(REPEAT);

    localparam logic [IW-1:0] START_IDX = MSB_FIRST ? IW'(W - 1) : '0;
    localparam logic [IW-1:0] END_IDX   = MSB_FIRST ? '0 : IW'(W - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(REPEAT - 1);

    logic [IW-1:0] idx_q, idx_d;
    logic [PW-1:0] pass_q, pass_d;

    assign idx       = idx_q;
    assign last_idx  = (idx_q == END_IDX);
    assign last_pass = (pass_q == LAST_PASS);
    assign idx_nxt   = idx_d;
    assign last_nxt  = (idx_d == END_IDX) && (pass_d == LAST_PASS);

    // Next index/pass. For W=1 last_idx is always true, so only wrap/hold occur.
    always_comb begin
        idx_d  = idx_q;
        pass_d = pass_q;
        if (restart) begin
            idx_d  = START_IDX;
            pass_d = '0;
        end else if (advance) begin
            if (!last_idx) begin
                idx_d = MSB_FIRST ? (idx_q - IW'(1)) : (idx_q + IW'(1));
            end else if (!last_pass) begin
                idx_d  = START_IDX;
                pass_d = pass_q + PW'(1);
            end
        end
    end

    // Counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            pass_q <= '0;
        end else begin
            idx_q  <= idx_d;
            pass_q <= pass_d;
        end
    end

endmodule

// File: rtl/param_bit_serializer.sv
// Serializes the compile-time constant VAL one bit per valid/ready beat,
// REPEAT full passes per run, LSB-first or MSB-first.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a run (honoured in IDLE or DONE only)
//   out_valid  : beat presented; out_ready accepts it
//   out_bit    : VAL[out_idx]
//   out_idx    : bit index presented
//   out_last   : final beat of the final pass
//   busy       : run in progress
//   done       : sticky run-complete flag
//   parity     : XOR of all accepted bits of the current run
module param_bit_serializer
    import param_bit_pkg::*;
#(
    parameter int unsigned     W         = 1,
    parameter logic [W-1:0]    VAL       = W'(1'b0),
    parameter int unsigned     REPEAT    = 1,
    parameter bit              MSB_FIRST = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_bit,
    output logic [idx_width(W)-1:0]   out_idx,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic                      parity
);

    localparam int unsigned IW = idx_width(W);

    // Reject illegal configurations at elaboration.
    if (W < 1) begin : g_bad_w
        $error("param_bit_serializer: W must be >= 1");
    end
    if (REPEAT < 1) begin : g_bad_repeat
        $error("param_bit_serializer: REPEAT must be >= 1");
    end

    state_t state_q, state_d;

    logic out_valid_q, out_valid_d;
    logic out_bit_q,   out_bit_d;
    logic out_last_q,  out_last_d;
    logic busy_q,      busy_d;
    logic done_q,      done_d;
    logic parity_q,    parity_d;

    logic          restart_c;
    logic          advance_c;
    logic          last_idx_c;
    logic          last_pass_c;
    logic [IW-1:0] idx_nxt_c;
    logic          last_nxt_c;
    logic          bit_nxt_c;

    param_bit_idx_ctr #(
        .W         (W),
        .REPEAT    (REPEAT),
        .MSB_FIRST (MSB_FIRST)
    ) u_idx_ctr (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart_c),
        .advance   (advance_c),
        .idx       (out_idx),
        .last_idx  (last_idx_c),
        .last_pass (last_pass_c),
        .idx_nxt   (idx_nxt_c),
        .last_nxt  (last_nxt_c)
    );

    // Bit of VAL for the upcoming beat; W=1 uses the only legal select VAL[0].
    if (W == 1) begin : g_w1
        logic unused_idx_nxt;
        assign unused_idx_nxt = ^idx_nxt_c;
        assign bit_nxt_c      = VAL[0];
    end else begin : g_wn
        assign bit_nxt_c = VAL[idx_nxt_c];
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = done_q;
        parity_d    = parity_q;
        restart_c   = 1'b0;
        advance_c   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    restart_c   = 1'b1;
                    state_d     = ST_SEND;
                    out_valid_d = 1'b1;
                    out_bit_d   = bit_nxt_c;
                    out_last_d  = last_nxt_c;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    parity_d    = 1'b0;
                end
            end
            ST_SEND: begin
                if (out_valid_q && out_ready) begin
                    parity_d = parity_q ^ out_bit_q;
                    if (last_idx_c && last_pass_c) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        // Index step or pass wrap, presented with no bubble.
                        advance_c  = 1'b1;
                        out_bit_d  = bit_nxt_c;
                        out_last_d = last_nxt_c;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            parity_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            parity_q    <= parity_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign parity    = parity_q;

endmodule

// File: tb/tb_param_bit_serializer.sv
// Bench for param_bit_serializer: several configurations run side by side,
// checked every cycle against a beat-position reference model.
module tb_param_bit_serializer;

    localparam int N = 7;
    localparam int unsigned WS [N] = '{1, 4, 4, 3, 4, 5, 8};
    localparam int unsigned VS [N] = '{32'h0, 32'hA, 32'hA, 32'h3, 32'h7, 32'h16, 32'hA7};
    localparam int unsigned RS [N] = '{1, 1, 1, 2, 1, 3, 2};
    localparam int unsigned MS [N] = '{0, 0, 1, 0, 0, 1, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start;
    logic [N-1:0] rdy;

    logic        v_a  [N];
    logic        b_a  [N];
    logic        l_a  [N];
    logic        bz_a [N];
    logic        d_a  [N];
    logic        p_a  [N];
    int unsigned i_a  [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned WG  = WS[g];
        localparam int unsigned IWG = (WG > 1) ? $clog2(WG) : 1;
        logic [IWG-1:0] idx_w;
        logic v, b, l, bz, d, p;

        param_bit_serializer #(
            .W         (WG),
            .VAL       (WG'(VS[g])),
            .REPEAT    (RS[g]),
            .MSB_FIRST (1'(MS[g]))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .out_valid (v),
            .out_ready (rdy[g]),
            .out_bit   (b),
            .out_idx   (idx_w),
            .out_last  (l),
            .busy      (bz),
            .done      (d),
            .parity    (p)
        );

        assign v_a[g]  = v;
        assign b_a[g]  = b;
        assign l_a[g]  = l;
        assign bz_a[g] = bz;
        assign d_a[g]  = d;
        assign p_a[g]  = p;
        assign i_a[g]  = 32'(idx_w);
    end

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a run is the sequence of W*REPEAT beats; pos is the
    // number of beats already accepted.
    bit          run_m  [N];
    bit          done_m [N];
    bit          par_m  [N];
    bit          zero_m [N];
    int unsigned pos_m  [N];

    function automatic int unsigned exp_idx(input int g, input int unsigned pos);
        int unsigned k;
        k = pos % WS[g];
        return (MS[g] != 0) ? (WS[g] - 1 - k) : k;
    endfunction

    function automatic bit exp_bit(input int g, input int unsigned pos);
        return 1'((VS[g] >> exp_idx(g, pos)) & 32'd1);
    endfunction

    task automatic check(input string tag, input int g, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s[cfg%0d] @%0t: got %0d expected %0d", tag, g, $time, got, exp);
    endtask

    // Apply inputs for one edge, advance the model, then compare all outputs.
    task automatic cyc(input bit s, input bit r, input logic [N-1:0] rd);
        rst   = r;
        start = s;
        rdy   = rd;
        @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            if (r) begin
                run_m[g] = 0; done_m[g] = 0; par_m[g] = 0; pos_m[g] = 0; zero_m[g] = 1;
            end else if (!run_m[g] && s) begin
                run_m[g] = 1; done_m[g] = 0; par_m[g] = 0; pos_m[g] = 0; zero_m[g] = 0;
            end else if (run_m[g] && rd[g]) begin
                par_m[g] = par_m[g] ^ exp_bit(g, pos_m[g]);
                pos_m[g] = pos_m[g] + 1;
                if (pos_m[g] == WS[g] * RS[g]) begin
                    run_m[g]  = 0;
                    done_m[g] = 1;
                end
            end

            check("out_valid", g, 32'(v_a[g]),  32'(run_m[g]));
            check("busy",      g, 32'(bz_a[g]), 32'(run_m[g]));
            check("done",      g, 32'(d_a[g]),  32'(done_m[g]));
            check("parity",    g, 32'(p_a[g]),  32'(par_m[g]));
            if (run_m[g]) begin
                check("out_idx",  g, i_a[g],         exp_idx(g, pos_m[g]));
                check("out_bit",  g, 32'(b_a[g]),    32'(exp_bit(g, pos_m[g])));
                check("out_last", g, 32'(l_a[g]),    32'(pos_m[g] == WS[g] * RS[g] - 1));
            end else begin
                check("out_last", g, 32'(l_a[g]), 32'd0);
                if (zero_m[g]) begin
                    check("rst_idx", g, i_a[g],      32'd0);
                    check("rst_bit", g, 32'(b_a[g]), 32'd0);
                end
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        rdy   = '0;
        for (int g = 0; g < N; g++) begin
            run_m[g] = 0; done_m[g] = 0; par_m[g] = 0; pos_m[g] = 0; zero_m[g] = 1;
        end

        // Reset and idle.
        cyc(0, 1, '0);
        cyc(0, 1, '0);
        cyc(0, 0, '0);
        cyc(1'b0, 1'b0, '1);

        // Full-throughput run; start re-pulsed on the second beat.
        cyc(1, 0, '1);
        for (int k = 0; k < 30; k++) cyc(k == 1, 0, '1);

        // Restart from DONE, stall for 3 cycles on the second beat.
        cyc(1, 0, '1);
        cyc(0, 0, '1);
        for (int k = 0; k < 3; k++) cyc(0, 0, '0);
        for (int k = 0; k < 30; k++) cyc(0, 0, '1);

        // Reset mid-run, then a clean run.
        cyc(1, 0, '1);
        cyc(0, 0, '1);
        cyc(0, 1, '1);
        cyc(0, 0, '1);
        cyc(0, 0, '1);
        cyc(1, 0, '1);
        for (int k = 0; k < 30; k++) cyc(0, 0, '1);

        // Random start/ready/reset traffic.
        for (int k = 0; k < 2000; k++) begin
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0, N'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
